avalon_uart_dumper: RTL
=======================

AVALON_UART_DUMPER -- requirements
Module: avalon_uart_dumper

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the word-count input.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a dump; honored only in IDLE.
REQ-005 SHALL have port base_address, input, 32: byte address of the first word, sampled on an accepted start.
REQ-006 SHALL have port word_count, input, CNT_W: number of 32-bit words to dump, sampled on an accepted start.
REQ-007 SHALL have port abort, input, 1: level request to stop early.
REQ-008 SHALL have port cfg_div, input, 16: clock cycles per UART bit; 0 is treated as 1.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a dump ends.
REQ-011 SHALL have port aborted, output, 1: valid with done; high if the dump ended through abort.
REQ-012 SHALL have Avalon master ports avn_read (output, 1), avn_address (output, 32), avn_readdata (input, 32) and avn_waitrequest (input, 1).
REQ-013 SHALL have port uart_txd, output, 1: serial 8N1 output, idles high.

Function
REQ-014 SHALL implement the states IDLE, READ, SEND and DONE.
REQ-015 IDLE: on start with word_count≠0 SHALL latch the address and count and enter READ; with word_count=0 SHALL enter DONE directly.
REQ-016 READ: SHALL hold avn_read=1 with avn_address equal to the current address until avn_waitrequest=0, then latch avn_readdata in that same cycle and enter SEND.
REQ-017 READ SHALL keep avn_read asserted while waitrequest is high, regardless of abort.
REQ-018 avn_read SHALL be 0 in every state other than READ.
REQ-019 SEND: SHALL transmit the latched word as 4 bytes, least-significant byte first.
REQ-020 Each byte SHALL be framed as a start bit (0), data bits 0..7 with LSB first, then a stop bit (1), with each bit lasting max(cfg_div,1) cycles; one byte therefore takes 10·max(cfg_div,1) cycles.
REQ-021 Bytes SHALL be sent back-to-back with no idle gap between them.
REQ-022 After the 4th stop bit: if the remaining count is greater than 1, SHALL decrement the count, add 4 to the address (modulo 2^32) and enter READ; otherwise SHALL enter DONE.
REQ-023 A word's first start bit SHALL begin the cycle after its read completes.
REQ-024 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 An abort seen in READ SHALL take effect after the pending read completes; the block SHALL then go to DONE with aborted=1 and SHALL NOT transmit that word.
REQ-026 An abort seen in SEND SHALL take effect after the current byte's stop bit; the block SHALL then go to DONE with aborted=1.
REQ-027 An abort seen in IDLE or DONE SHALL be ignored.
REQ-028 A start while busy=1 SHALL be ignored.
REQ-029 If start and abort arrive in the same IDLE cycle, start SHALL win.
REQ-030 cfg_div SHALL be sampled at the start of each bit period; a change takes effect on the next bit.
REQ-031 uart_txd SHALL be 1 in IDLE, READ and DONE.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE with busy=0, done=0, aborted=0, avn_read=0, avn_address=0 and uart_txd=1.
REQ-033 Reset asserted mid-frame SHALL drive uart_txd=1 immediately and discard the remaining count and byte index.

Structure
REQ-034 The state enum, the UART frame constants (10 bits per frame, 4 bytes per word) and the address increment (4) SHALL live in the shared SoC package.
REQ-035 Serialization SHALL be done by one sub-module, uart_tx_core, with inputs tx_valid, tx_data[7:0] and cfg_div and outputs tx_ready and uart_txd.
REQ-036 The top level SHALL hold only the FSM, the address/count registers and the word/byte buffer.

Verification
REQ-037 cfg_div=4, base 0x100, count 1, readdata 0x44332211 with no wait -> one read at 0x100; bytes 0x11,0x22,0x33,0x44 on uart_txd; 160 cycles of SEND; one done pulse with aborted=0.
REQ-038 count 3, base 0xFFFFFFF8, waitrequest high for 5 cycles on each read -> reads at 0xFFFFFFF8, 0xFFFFFFFC and 0x00000000; avn_read and avn_address stable while waitrequest is high; 12 bytes sent in order.
REQ-039 count 0 -> done pulse 2 cycles after start; no avn_read; uart_txd stays high.
REQ-040 count 4, abort raised mid-bit of byte 1 of word 0 -> byte 1 completes, then done=1 with aborted=1; exactly 2 bytes sent; no further reads.
REQ-041 cfg_div=0 -> each bit lasts 1 cycle; a second start during busy is ignored; rst asserted mid-byte -> uart_txd=1 and busy=0 the same cycle.

Source files
------------

// File: rtl/avalon_uart_dumper_pkg.sv
// Shared definitions for the Avalon-to-UART memory dumper: FSM states,
// UART frame geometry and the word address stride.
package avalon_uart_dumper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BIT_IDX_W      = $clog2(FRAME_BITS);
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam logic [31:0] ADDR_INC       = 32'd4;

    // A zero divider would stall the bit timer, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == '0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/avalon_uart_dumper_uart_tx_core.sv
// 8N1 serializer; tx_ready rises in the last cycle of a stop bit so that a
// new byte can follow with no idle gap.
module uart_tx_core
    import avalon_uart_dumper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [15:0] cfg_div,
    output logic       tx_ready,
    output logic       uart_txd
);

    logic                 busy_q, busy_d;
    logic [9:0]           sh_q, sh_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    logic [15:0]          div_q, div_d;
    logic                 last_bit;

    assign last_bit = (bit_q == BIT_IDX_W'(FRAME_BITS - 1));
    assign tx_ready = !busy_q || ((div_q == '0) && last_bit);
    assign uart_txd = busy_q ? sh_q[0] : 1'b1;

    always_comb begin
        busy_d = busy_q;
        sh_d   = sh_q;
        bit_d  = bit_q;
        div_d  = div_q;
        if (busy_q) begin
            if (div_q != '0) begin
                div_d = div_q - 16'd1;
            end else if (!last_bit) begin
                sh_d  = {1'b1, sh_q[9:1]};
                bit_d = bit_q + BIT_IDX_W'(1);
                div_d = eff_div(cfg_div) - 16'd1;
            end else begin
                busy_d = 1'b0;
            end
        end
        if (tx_valid && tx_ready) begin
            busy_d = 1'b1;
            sh_d   = {1'b1, tx_data, 1'b0};
            bit_d  = '0;
            div_d  = eff_div(cfg_div) - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            sh_q   <= '1;
            bit_q  <= '0;
            div_q  <= '0;
        end else begin
            busy_q <= busy_d;
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/avalon_uart_dumper.sv
// Reads word_count 32-bit words over Avalon starting at base_address and
// streams each one LSB-first out of a UART.
module avalon_uart_dumper
    import avalon_uart_dumper_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_address,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic [15:0]      cfg_div,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             avn_read,
    output logic [31:0]      avn_address,
    input  logic [31:0]      avn_readdata,
    input  logic             avn_waitrequest,
    output logic             uart_txd
);

    dump_state_t           state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           word_q, word_d;
    logic [BYTE_IDX_W-1:0] byte_q, byte_d;
    logic                  abort_q, abort_d;
    logic                  aborted_q, aborted_d;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign aborted     = done && aborted_q;
    assign avn_read    = (state_q == ST_READ);
    assign avn_address = addr_q;

    // byte_q is the index of the next byte to load; wrapping to 0 marks the
    // last byte of the word as in flight.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        byte_d    = byte_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;
        tx_valid  = 1'b0;
        tx_data   = word_q[{byte_q, 3'b000} +: 8];
        case (state_q)
            ST_IDLE: begin
                abort_d   = 1'b0;
                aborted_d = 1'b0;
                if (start) begin
                    if (word_count != '0) begin
                        addr_d  = base_address;
                        cnt_d   = word_count;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (abort) abort_d = 1'b1;
                if (!avn_waitrequest) begin
                    if (abort || abort_q) begin
                        aborted_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        word_d   = avn_readdata;
                        tx_valid = 1'b1;
                        tx_data  = avn_readdata[7:0];
                        byte_d   = BYTE_IDX_W'(1);
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (abort) abort_d = 1'b1;
                if (tx_ready) begin
                    if (abort || abort_q) begin
                        aborted_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (byte_q != '0) begin
                        tx_valid = 1'b1;
                        byte_d   = byte_q + BYTE_IDX_W'(1);
                    end else if (cnt_q > CNT_W'(1)) begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        addr_d  = addr_q + ADDR_INC;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            byte_q    <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            byte_q    <= byte_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    uart_tx_core u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .cfg_div  (cfg_div),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd)
    );

endmodule
